// File: rtl/axis_head_pkg.sv
// axis_head_pkg
//   Shared types and helpers for the head insert and head cut stream paths.
//   - state_e    : packet sequencing states
//   - keep_count : number of leading (MSB-side) ones in a tkeep word
//   - keep_mask  : n ones aligned to the MSB of a dx-bit tkeep word
//   Helpers work on a MAX_DX-wide word. Callers zero-extend their tkeep into it
//   and truncate results back to DX bits.
package axis_head_pkg;

  localparam int MAX_DX = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY,
    ST_FLUSH
  } state_e;

  // Bit dx-1 is byte 0. Counting stops at the first zero, so a
  // non-contiguous keep counts only its leading run.
  function automatic int keep_count(input logic [MAX_DX-1:0] keep, input int dx);
    int   c;
    logic run;
    c   = 0;
    run = 1'b1;
    for (int i = MAX_DX - 1; i >= 0; i--) begin
      if (i < dx) begin
        if (run && keep[i]) c++;
        else                run = 1'b0;
      end
    end
    return c;
  endfunction

  function automatic logic [MAX_DX-1:0] keep_mask(input int n, input int dx);
    logic [MAX_DX-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DX; i++) begin
      if (i < dx && (dx - 1 - i) < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_head_insert_verc_realign.sv
// axis_byte_realign
//   Byte realignment stage for header insertion. It holds a carry word and
//   merges the carry with the incoming beat, shifted by r bytes.
//   Ports:
//     aclk_i, aresetn_i : clock, synchronous active-low reset
//     r_i               : shift amount in bytes (0..DX-1)
//     load_i/load_data_i: preload the carry (MSB-aligned header remainder)
//     adv_i             : an input beat is consumed; carry takes its tail
//     in_data_i         : input beat, byte 0 in the MSBs
//     out_data_o        : {carry bytes 0..r-1, input bytes 0..DX-r-1}
//     carry_o           : current carry, MSB-aligned (the flush beat)
module axis_byte_realign #(
  parameter  int DX        = 4,
  parameter  int BYTE_BITS = 8,
  localparam int DW        = DX * BYTE_BITS,
  localparam int RW        = (DX > 1) ? $clog2(DX) : 1
) (
  input  logic          aclk_i,
  input  logic          aresetn_i,
  input  logic [RW-1:0] r_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          adv_i,
  input  logic [DW-1:0] in_data_i,
  output logic [DW-1:0] out_data_o,
  output logic [DW-1:0] carry_o
);

  logic [DW-1:0] carry_q, carry_d;

  // Output byte i is carry byte i for i < r, else input byte i-r.
  // The new carry is input bytes DX-r..DX-1 moved to the top. No index wraps.
  always_comb begin
    out_data_o = '0;
    carry_d    = '0;
    for (int i = 0; i < DX; i++) begin
      if (i < int'(r_i)) begin
        out_data_o[(DX-1-i)*BYTE_BITS +: BYTE_BITS] = carry_q[(DX-1-i)*BYTE_BITS +: BYTE_BITS];
        carry_d[(DX-1-i)*BYTE_BITS +: BYTE_BITS]    = in_data_i[(int'(r_i)-1-i)*BYTE_BITS +: BYTE_BITS];
      end else begin
        out_data_o[(DX-1-i)*BYTE_BITS +: BYTE_BITS] = in_data_i[(DX-1-i+int'(r_i))*BYTE_BITS +: BYTE_BITS];
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i)  carry_q <= '0;
    else if (load_i) carry_q <= load_data_i;
    else if (adv_i)  carry_q <= carry_d;
  end

  assign carry_o = carry_q;

endmodule

// File: rtl/axis_head_insert_verc.sv
// axis_head_insert_verc
//   Prepends a 0..MAX_HEAD_BYTES byte header to each AXI-stream packet and
//   realigns the payload so that header and payload are back-to-back.
//   Ports:
//     aclk_i, aresetn_i      : clock, synchronous active-low reset
//     head_bytes_i           : header length H (clamped to MAX_HEAD_BYTES)
//     head_data_i            : header bytes, byte 0 in the MSBs
//     head_taken_o           : pulses on the cycle the header is sampled
//     origin_t*_i/_o         : payload input stream (slave side)
//     out_t*_o / out_tready_i: header+payload output stream (master side)
module axis_head_insert_verc
  import axis_head_pkg::*;
#(
  parameter  int BYTE_BITS      = 8,
  parameter  int DSIZE          = 32,
  parameter  int DX             = DSIZE / BYTE_BITS,
  parameter  int MAX_HEAD_BYTES = 32,
  parameter  int HW             = $clog2(MAX_HEAD_BYTES + 1),
  localparam int DW             = DX * BYTE_BITS,
  localparam int HB             = MAX_HEAD_BYTES * BYTE_BITS
) (
  input  logic          aclk_i,
  input  logic          aresetn_i,
  input  logic [HW-1:0] head_bytes_i,
  input  logic [HB-1:0] head_data_i,
  output logic          head_taken_o,
  input  logic [DW-1:0] origin_tdata_i,
  input  logic [DX-1:0] origin_tkeep_i,
  input  logic          origin_tvalid_i,
  input  logic          origin_tlast_i,
  output logic          origin_tready_o,
  output logic [DW-1:0] out_tdata_o,
  output logic [DX-1:0] out_tkeep_o,
  output logic          out_tvalid_o,
  output logic          out_tlast_o,
  output logic          out_tuser_o,
  input  logic          out_tready_i
);

  localparam int RW = (DX > 1) ? $clog2(DX) : 1;
  localparam int KW = $clog2(2 * DX) + 1;

  if (DX < 1 || DX > MAX_DX || MAX_HEAD_BYTES < DX) begin : g_bad_param
    $error("axis_head_insert_verc: DX must be 1..16 and not exceed MAX_HEAD_BYTES");
  end

  state_e        state_q, state_d;
  logic [HW-1:0] q_q, q_d, hcnt_q, hcnt_d;
  logic [RW-1:0] r_q, r_d;
  logic [HB-1:0] head_q, head_d;
  logic [KW-1:0] fk_q, fk_d;

  logic [HW-1:0] h_clamp, hq;
  logic [RW-1:0] hr;
  logic [KW-1:0] kr;

  logic          push_vld, push_last, push_rdy, push_fire;
  logic [DW-1:0] push_data;
  logic [DX-1:0] push_keep;
  logic          carry_ld, adv, in_rdy, taken;
  logic [DW-1:0] rl_out, rl_carry;

  // Output register plus skid
  logic          out_vld_q, sk_vld_q;
  logic [DW-1:0] out_data_q, sk_data_q;
  logic [DX-1:0] out_keep_q, sk_keep_q;
  logic          out_last_q, sk_last_q;

  assign h_clamp = (head_bytes_i > HW'(MAX_HEAD_BYTES)) ? HW'(MAX_HEAD_BYTES) : head_bytes_i;
  assign hq      = h_clamp / HW'(DX);
  assign hr      = RW'(h_clamp % HW'(DX));
  assign kr      = KW'(keep_count(MAX_DX'(origin_tkeep_i), DX)) + KW'(r_q);

  // Readiness comes only from the registered skid state, which keeps
  // out_tready_i off every combinational path.
  assign push_rdy  = !sk_vld_q;
  assign push_fire = push_vld && push_rdy;

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    r_d       = r_q;
    hcnt_d    = hcnt_q;
    head_d    = head_q;
    fk_d      = fk_q;
    taken     = 1'b0;
    in_rdy    = 1'b0;
    push_vld  = 1'b0;
    push_data = '0;
    push_keep = '0;
    push_last = 1'b0;
    carry_ld  = 1'b0;
    adv       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (origin_tvalid_i) begin
          taken    = 1'b1;
          q_d      = hq;
          r_d      = hr;
          head_d   = head_data_i;
          hcnt_d   = '0;
          carry_ld = 1'b1;
          if (hq == '0) begin
            state_d = ST_BODY;
          end else begin
            state_d = ST_HEAD;
            // The first header beat goes out in the sample cycle, so valid
            // rises the cycle after head_taken.
            if (push_rdy) begin
              push_vld  = 1'b1;
              push_data = head_data_i[HB-1 -: DW];
              push_keep = '1;
              head_d    = head_data_i << DW;
              hcnt_d    = HW'(1);
              if (hq == HW'(1)) state_d = ST_BODY;
            end
          end
        end
      end
      ST_HEAD: begin
        push_vld  = 1'b1;
        push_data = head_q[HB-1 -: DW];
        push_keep = '1;
        if (push_rdy) begin
          head_d   = head_q << DW;
          carry_ld = 1'b1;
          hcnt_d   = hcnt_q + HW'(1);
          if (hcnt_q + HW'(1) == q_q) state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        in_rdy    = push_rdy;
        push_vld  = origin_tvalid_i;
        push_data = rl_out;
        push_keep = '1;
        if (origin_tvalid_i && push_rdy) begin
          adv = 1'b1;
          if (origin_tlast_i) begin
            if (kr <= KW'(DX)) begin
              push_last = 1'b1;
              push_keep = DX'(keep_mask(int'(kr), DX));
              state_d   = ST_IDLE;
            end else begin
              fk_d    = kr - KW'(DX);
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        push_vld  = 1'b1;
        push_data = rl_carry;
        push_keep = DX'(keep_mask(int'(fk_q), DX));
        push_last = 1'b1;
        if (push_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Carry always mirrors the top of the header word being written, so it
  // holds bytes Q*DX..H-1 by the time BODY starts.
  axis_byte_realign #(
    .DX       (DX),
    .BYTE_BITS(BYTE_BITS)
  ) u_realign (
    .aclk_i     (aclk_i),
    .aresetn_i  (aresetn_i),
    .r_i        (r_q),
    .load_i     (carry_ld),
    .load_data_i(head_d[HB-1 -: DW]),
    .adv_i      (adv),
    .in_data_i  (origin_tdata_i),
    .out_data_o (rl_out),
    .carry_o    (rl_carry)
  );

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      hcnt_q  <= '0;
      head_q  <= '0;
      fk_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      hcnt_q  <= hcnt_d;
      head_q  <= head_d;
      fk_q    <= fk_d;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      sk_vld_q   <= 1'b0;
      sk_data_q  <= '0;
      sk_keep_q  <= '0;
      sk_last_q  <= 1'b0;
    end else if (!out_vld_q || out_tready_i) begin
      if (sk_vld_q) begin
        out_vld_q  <= 1'b1;
        out_data_q <= sk_data_q;
        out_keep_q <= sk_keep_q;
        out_last_q <= sk_last_q;
        sk_vld_q   <= 1'b0;
      end else if (push_fire) begin
        out_vld_q  <= 1'b1;
        out_data_q <= push_data;
        out_keep_q <= push_keep;
        out_last_q <= push_last;
      end else begin
        out_vld_q  <= 1'b0;
      end
    end else if (push_fire) begin
      sk_vld_q  <= 1'b1;
      sk_data_q <= push_data;
      sk_keep_q <= push_keep;
      sk_last_q <= push_last;
    end
  end

  assign head_taken_o    = aresetn_i && taken;
  assign origin_tready_o = aresetn_i && in_rdy;
  assign out_tvalid_o    = out_vld_q;
  assign out_tdata_o     = out_data_q;
  assign out_tkeep_o     = out_keep_q;
  assign out_tlast_o     = out_last_q;
  assign out_tuser_o     = 1'b0;

endmodule

// File: tb/tb_axis_head_insert_verc.sv
module tb_axis_head_insert_verc;
  localparam int BB   = 8;
  localparam int DX   = 4;
  localparam int DW   = DX * BB;
  localparam int MAXH = 32;
  localparam int HW   = 6;
  localparam int HB   = MAXH * BB;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DX-1:0] k;
    logic          l;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [HW-1:0] head_bytes = '0;
  logic [HB-1:0] head_data = '0;
  logic          head_taken;
  logic [DW-1:0] s_tdata = '0;
  logic [DX-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [DW-1:0] m_tdata;
  logic [DX-1:0] m_tkeep;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready = 1'b1;

  int    tests = 0, fails = 0;
  int    rdy_pct = 100;
  bit    mon_en = 1'b1;
  int    taken_cnt = 0, npkts = 0;
  beat_t expq[$];

  axis_head_insert_verc #(.BYTE_BITS(BB), .DSIZE(DW), .MAX_HEAD_BYTES(MAXH)) dut (
    .aclk_i(aclk), .aresetn_i(aresetn),
    .head_bytes_i(head_bytes), .head_data_i(head_data), .head_taken_o(head_taken),
    .origin_tdata_i(s_tdata), .origin_tkeep_i(s_tkeep), .origin_tvalid_i(s_tvalid),
    .origin_tlast_i(s_tlast), .origin_tready_o(s_tready),
    .out_tdata_o(m_tdata), .out_tkeep_o(m_tkeep), .out_tvalid_o(m_tvalid),
    .out_tlast_o(m_tlast), .out_tuser_o(m_tuser), .out_tready_i(m_tready)
  );

  always #5 aclk = ~aclk;

  function automatic logic [DX-1:0] kmask(input int n);
    logic [DX-1:0] m;
    for (int i = 0; i < DX; i++) m[DX-1-i] = (i < n);
    return m;
  endfunction

  // Reference model: header bytes then payload bytes as one byte list,
  // cut into DX-byte beats; only the final beat is partial.
  task automatic build_expect(input byte unsigned ob[$]);
    beat_t e;
    int    n;
    for (int b = 0; b < ob.size(); b += DX) begin
      n   = (ob.size() - b < DX) ? ob.size() - b : DX;
      e.d = '0;
      for (int j = 0; j < n; j++) e.d[(DX-1-j)*BB +: BB] = ob[b+j];
      e.l = (b + DX >= ob.size());
      e.k = e.l ? kmask(n) : '1;
      expq.push_back(e);
    end
  endtask

  // stop_after > 0: abandon the packet after that many accepted beats and
  // expect nothing from it.
  task automatic send_pkt(input int h_in, input int len, input int gap_pct, input int stop_after);
    logic [HB-1:0]  hd;
    byte unsigned   ob[$];
    byte unsigned   pl[$];
    int             h, nb, k;
    bit             acc, took;
    logic [DX-1:0]  kp;
    h = (h_in > MAXH) ? MAXH : h_in;
    for (int i = 0; i < MAXH; i++) begin
      hd[(MAXH-1-i)*BB +: BB] = 8'($urandom);
      if (i < h) ob.push_back(hd[(MAXH-1-i)*BB +: BB]);
    end
    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      ob.push_back(pl[i]);
    end
    if (stop_after == 0) build_expect(ob);
    npkts++;
    nb = (len + DX - 1) / DX;
    for (int b = 0; b < nb; b++) begin
      if (stop_after > 0 && b == stop_after) break;
      while ($urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
      end
      k = (len - b*DX < DX) ? len - b*DX : DX;
      for (int j = 0; j < DX; j++) s_tdata[(DX-1-j)*BB +: BB] = (j < k) ? pl[b*DX+j] : 8'($urandom);
      s_tlast = (b == nb - 1);
      kp = DX'($urandom);
      if (s_tlast) kp = kmask(k) | (kp & ~kmask((k + 1 > DX) ? DX : k + 1));
      s_tkeep = kp;
      if (b == 0) begin
        head_bytes = HW'(h_in);
        head_data  = hd;
      end
      s_tvalid = 1'b1;
      do begin
        @(negedge aclk);
        acc  = s_tready;
        took = head_taken;
        @(posedge aclk); #1;
        // Once sampled, header inputs must no longer matter.
        if (took) begin
          head_bytes = HW'($urandom);
          head_data  = {8{$urandom}};
        end
      end while (!acc);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && expq.size() > 0; i++) @(negedge aclk);
    repeat (4) @(posedge aclk);
    #1;
  endtask

  initial begin : rdy_gen
    forever begin
      @(posedge aclk); #1;
      m_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  initial begin : monitor
    beat_t prev, cur, e;
    bit    stalled, ok;
    stalled = 1'b0;
    forever begin
      @(negedge aclk);
      if (head_taken) taken_cnt++;
      cur = '{d: m_tdata, k: m_tkeep, l: m_tlast};
      if (mon_en && stalled) begin
        tests++;
        if (!m_tvalid || cur != prev) begin
          fails++;
          $display("FAIL stall_hold: got v=%0b %h/%b/%b required v=1 %h/%b/%b",
                   m_tvalid, cur.d, cur.k, cur.l, prev.d, prev.k, prev.l);
        end
      end
      stalled = mon_en && m_tvalid && !m_tready;
      prev    = cur;
      if (mon_en && m_tvalid && m_tready) begin
        tests++;
        if (expq.size() == 0) begin
          fails++;
          $display("FAIL beat_extra: got %h/%b/%b required no beat", cur.d, cur.k, cur.l);
        end else begin
          e  = expq.pop_front();
          ok = (cur.l == e.l) && (!e.l || cur.k == e.k) && (m_tuser == 1'b0);
          for (int i = 0; i < DX; i++)
            if (e.k[DX-1-i] && cur.d[(DX-1-i)*BB +: BB] != e.d[(DX-1-i)*BB +: BB]) ok = 1'b0;
          if (!ok) begin
            fails++;
            $display("FAIL out_beat: got %h/%b/last=%b/user=%b required %h/%b/last=%b",
                     cur.d, cur.k, cur.l, m_tuser, e.d, e.k, e.l);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, %0d beats still expected", expq.size());
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : main
    // Reset state, with a valid input present to show it is not taken.
    s_tvalid = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    tests++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata, m_tuser, s_tready, head_taken} != '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b l=%b k=%b d=%h rdy=%b taken=%b required all 0",
               m_tvalid, m_tlast, m_tkeep, m_tdata, s_tready, head_taken);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    repeat (2) @(posedge aclk); #1;

    // Directed cases
    rdy_pct = 100;
    send_pkt(6, 8, 0, 0);
    send_pkt(2, 7, 0, 0);
    send_pkt(0, 12, 0, 0);
    send_pkt(4, 12, 0, 0);
    send_pkt(40, 5, 0, 0);
    send_pkt(3, 1, 0, 0);
    send_pkt(5, 3, 0, 0);
    drain();

    // Randomized traffic under backpressure
    rdy_pct = 70;
    for (int p = 0; p < 1000; p++)
      send_pkt($urandom_range(0, MAXH), $urandom_range(1, 64), 30, 0);
    rdy_pct = 100;
    drain();

    // Reset in the middle of a payload
    mon_en = 1'b0;
    send_pkt(2, 20, 0, 2);
    s_tvalid = 1'b1;
    aresetn  = 1'b0;
    @(negedge aclk);
    tests++;
    if (s_tready !== 1'b0 || head_taken !== 1'b0) begin
      fails++;
      $display("FAIL reset_inputs: got rdy=%b taken=%b required 0 0", s_tready, head_taken);
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    @(negedge aclk);
    tests++;
    if ({m_tvalid, m_tlast, m_tkeep, m_tdata} != '0) begin
      fails++;
      $display("FAIL reset_mid_body: got v=%b l=%b k=%b d=%h required all 0",
               m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    expq.delete();
    mon_en = 1'b1;
    @(posedge aclk); #1;
    send_pkt(1, 4, 0, 0);
    drain();

    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL beats_missing: got %0d outstanding required 0", expq.size());
    end
    tests++;
    if (taken_cnt != npkts) begin
      fails++;
      $display("FAIL head_taken_count: got %0d required %0d", taken_cnt, npkts);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
